// File: rtl/fetch_stage_pkg.sv
// Shared widths, stall encodings and helpers for the IF stage.
package fetch_stage_pkg;

    // Width of the pipeline stall bus; bit 0 controls the PC, bit 1 the IF/ID register
    localparam int STALL_W     = 6;

    // Branch bus from ID: {br_e, br_addr[31:0]}
    localparam int BR_WD       = 33;

    // IF -> ID bus: {ce, pc[31:0]}
    localparam int IF_TO_ID_WD = 33;

    // Stall bit encodings
    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;

    // Default boot address (MIPS kseg1 boot ROM)
    localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;

    // Sequential next fetch address; wraps naturally at 32 bits
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_br_redirect_hold.sv
// Holds a branch redirect that arrives while the PC is frozen, so it can be
// applied on the first edge after the stall releases.
module br_redirect_hold
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    input  logic        br_e,
    input  logic [31:0] br_addr,
    output logic        pend,
    output logic [31:0] pend_addr
);

    logic        pend_q;
    logic        pend_d;
    logic [31:0] pend_addr_q;
    logic [31:0] pend_addr_d;

    // Capture the latest redirect during a hold; drop it on the first non-held edge,
    // where either it or a fresher redirect has been consumed by the PC logic
    always_comb begin
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        if (hold) begin
            if (br_e) begin
                pend_d      = 1'b1;
                pend_addr_d = br_addr;
            end
        end else begin
            pend_d = 1'b0;
        end
    end

    // Pending-redirect registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= 1'b0;
            pend_addr_q <= 32'h0000_0000;
        end else begin
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign pend      = pend_q;
    assign pend_addr = pend_addr_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, issues one instruction
// SRAM read per cycle, honours the PC stall and applies redirects from ID.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter int          CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic [BR_WD-1:0]       br_bus,
    output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [31:0]            inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    output logic [CNT_W-1:0]       fetch_cnt
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    fetch_state_e     state_q;
    fetch_state_e     state_d;
    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic             ce_q;
    logic             ce_d;
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] fetch_cnt_d;

    logic             br_e;
    logic [31:0]      br_addr;
    logic             pc_stop;
    logic             hold_redirect;
    logic             pend;
    logic [31:0]      pend_addr;
    logic [31:0]      next_pc;
    logic             unused_stall_bits;

    assign br_e    = br_bus[32];
    assign br_addr = br_bus[31:0];
    assign pc_stop = (stall[0] == STOP);

    // Only stall[0] steers the PC; the IF/ID bubble is inserted in ID
    assign unused_stall_bits = ^stall[STALL_W-1:1];

    br_redirect_hold u_br_redirect_hold (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold_redirect),
        .br_e      (br_e),
        .br_addr   (br_addr),
        .pend      (pend),
        .pend_addr (pend_addr)
    );

    // Next sequential-or-redirected PC: a fresh redirect beats a held one
    always_comb begin
        next_pc = pc_plus4(pc_q);
        if (br_e) begin
            next_pc = br_addr;
        end else if (pend) begin
            next_pc = pend_addr;
        end
    end

    // Boot/run/hold sequencing of the PC and chip-enable
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        ce_d          = ce_q;
        hold_redirect = 1'b0;
        case (state_q)
            S_BOOT: begin
                if (!pc_stop) begin
                    pc_d    = RESET_VECTOR;
                    ce_d    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN, S_HOLD: begin
                if (pc_stop) begin
                    hold_redirect = 1'b1;
                    state_d       = S_HOLD;
                end else begin
                    pc_d    = next_pc;
                    ce_d    = 1'b1;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // Count cycles in which a real fetch advances
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        if (ce_q && !pc_stop) begin
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end
    end

    // PC, chip-enable, state and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_VECTOR - 32'd4;
            ce_q        <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign if_to_id_bus    = {ce_q, pc_q};
    assign inst_sram_en    = ce_q;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wdata = 32'h0000_0000;
    assign fetch_cnt       = fetch_cnt_q;

endmodule
